// File: rtl/ip_tree_if.sv
// ----------------------------------------------------------------------------
// ip_tree_if
// Operand/result bundle for one 3:2 carry-save compressor stage.
//   a, b, c  : three P_SIZE-bit unsigned operands (driven by the master)
//   out0     : registered sum vector   (driven by the slave)
//   out1     : registered carry vector, already shifted to its bit weight
// Modports:
//   master : the producer of operands / consumer of results
//   slave  : the compressor stage itself
// ----------------------------------------------------------------------------
interface ip_tree_if #(
    parameter int P_SIZE = 16
);
    logic [P_SIZE-1:0] a;
    logic [P_SIZE-1:0] b;
    logic [P_SIZE-1:0] c;
    logic [P_SIZE-1:0] out0;
    logic [P_SIZE-1:0] out1;

    modport master (
        output a, b, c,
        input  out0, out1
    );

    modport slave (
        input  a, b, c,
        output out0, out1
    );
endinterface

// File: rtl/ip_tree.sv
// ----------------------------------------------------------------------------
// ip_tree
// Registered 3:2 carry-save compressor, one level of an adder tree.
// Reduces a, b, c to a sum vector and a carry vector such that
// out0 + out1 == a + b + c (mod 2^P_SIZE). Latency one cycle, one operand set
// per cycle, no handshake.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous, active-low reset; clears out0/out1
//   bus    : ip_tree_if.slave carrying a, b, c (in) and out0, out1 (out)
//
// Parameters:
//   P_SIZE : operand/result width, >= 2
//
// Optional build macro:
//   IP_TREE_SELFCHECK_EN : adds a simulation-only checker that compares the
//                          registered outputs against (a+b+c) mod 2^P_SIZE.
//                          Ports and synthesised logic are unchanged.
// ----------------------------------------------------------------------------
module ip_tree #(
    parameter int P_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ip_tree_if.slave    bus
);

    logic [P_SIZE-1:0] s;
    logic [P_SIZE-1:0] k;
    logic [P_SIZE-1:0] sum;
    logic [P_SIZE-1:0] carry;

    // Independent full-adder cells; there is deliberately no carry chain.
    for (genvar i = 0; i < P_SIZE; i++) begin : g_cell
        assign s[i] = bus.a[i] ^ bus.b[i] ^ bus.c[i];
        assign k[i] = (bus.a[i] & bus.b[i]) |
                      (bus.a[i] & bus.c[i]) |
                      (bus.b[i] & bus.c[i]);
    end

    assign sum   = s;
    // Carry of cell i has weight 2^(i+1); the MSB carry falls off the top,
    // which is what makes the stage modulo 2^P_SIZE.
    assign carry = {k[P_SIZE-2:0], 1'b0};

    logic unused_msb_carry;
    assign unused_msb_carry = k[P_SIZE-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out0 <= '0;
            bus.out1 <= '0;
        end else begin
            bus.out0 <= sum;
            bus.out1 <= carry;
        end
    end

`ifdef IP_TREE_SELFCHECK_EN
    // Reference sum and the operands that produced it, registered alongside
    // out0/out1 so all of them describe the same operand set.
    logic [P_SIZE-1:0] ref_sum;
    logic [P_SIZE-1:0] ref_a;
    logic [P_SIZE-1:0] ref_b;
    logic [P_SIZE-1:0] ref_c;
    logic [P_SIZE-1:0] out_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_sum <= '0;
            ref_a   <= '0;
            ref_b   <= '0;
            ref_c   <= '0;
        end else begin
            ref_sum <= bus.a + bus.b + bus.c;
            ref_a   <= bus.a;
            ref_b   <= bus.b;
            ref_c   <= bus.c;
        end
    end

    assign out_total = bus.out0 + bus.out1;

    // Runs before this edge's register updates land, so it sees the pair
    // registered on the previous edge.
    always @(posedge clk) begin
        if (rst_n && !$isunknown(ref_sum) && (out_total !== ref_sum)) begin
            $error("ip_tree selfcheck @%0t: a=%h b=%h c=%h out0=%h out1=%h",
                   $time, ref_a, ref_b, ref_c, bus.out0, bus.out1);
        end
    end
`endif

endmodule

// File: tb/tb_ip_tree.sv
// ----------------------------------------------------------------------------
// tb_ip_tree
// Scoreboard bench for ip_tree: every operand set driven pushes its expected
// out0/out1 into a queue; one edge later the entry is popped and compared,
// together with the arithmetic invariant out0 + out1 == a + b + c.
// ----------------------------------------------------------------------------
module tb_ip_tree;
    localparam int P_SIZE = 16;

    typedef struct {
        logic [P_SIZE-1:0] a;
        logic [P_SIZE-1:0] b;
        logic [P_SIZE-1:0] c;
        logic [P_SIZE-1:0] exp0;
        logic [P_SIZE-1:0] exp1;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ip_tree_if #(.P_SIZE(P_SIZE)) bus ();

    ip_tree #(.P_SIZE(P_SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    txn_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [P_SIZE-1:0] got,
                         input logic [P_SIZE-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit-level reference for carry-save form: sum bit = odd parity of the
    // three inputs, carry bit = at least two inputs set, moved up one weight.
    function automatic txn_t model(input logic [P_SIZE-1:0] a,
                                   input logic [P_SIZE-1:0] b,
                                   input logic [P_SIZE-1:0] c);
        txn_t t;
        t.a = a; t.b = b; t.c = c;
        t.exp0 = '0;
        t.exp1 = '0;
        for (int i = 0; i < P_SIZE; i++) begin
            int n;
            n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            t.exp0[i] = n[0];
            if (i < P_SIZE - 1) t.exp1[i+1] = n[1];
        end
        return t;
    endfunction

    task automatic drive(input txn_t t);
        @(negedge clk);
        bus.a = t.a;
        bus.b = t.b;
        bus.c = t.c;
        exp_q.push_back(t);
    endtask

    task automatic collect(input string tag);
        txn_t t;
        logic [P_SIZE-1:0] total, ref_total;
        @(posedge clk);
        #1;
        t = exp_q.pop_front();
        check({tag, "_out0"}, bus.out0, t.exp0);
        check({tag, "_out1"}, bus.out1, t.exp1);
        total     = bus.out0 + bus.out1;
        ref_total = t.a + t.b + t.c;
        check({tag, "_sum"}, total, ref_total);
    endtask

    task automatic directed(input string tag,
                            input logic [P_SIZE-1:0] a, input logic [P_SIZE-1:0] b,
                            input logic [P_SIZE-1:0] c, input logic [P_SIZE-1:0] e0,
                            input logic [P_SIZE-1:0] e1);
        txn_t t;
        t.a = a; t.b = b; t.c = c; t.exp0 = e0; t.exp1 = e1;
        drive(t);
        collect(tag);
    endtask

    task automatic random_txn(input string tag);
        drive(model(P_SIZE'($urandom), P_SIZE'($urandom), P_SIZE'($urandom)));
        collect(tag);
    endtask

    initial begin
        // Reset with random inputs, checked before the first clock edge.
        bus.a = P_SIZE'($urandom);
        bus.b = P_SIZE'($urandom);
        bus.c = P_SIZE'($urandom);
        #2;
        check("rst_out0", bus.out0, '0);
        check("rst_out1", bus.out1, '0);
        // Outputs must stay 0 across edges while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_out0", bus.out0, '0);
        check("rst_hold_out1", bus.out1, '0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("basic",    16'd11,   16'd22,   16'd33,   16'h003C, 16'h0006);
        directed("all_ones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE);
        directed("msb_drop", 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000);
        directed("zero",     16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Back-to-back stream: one set per cycle, each checked one edge later.
        for (int n = 0; n < 10000; n++) random_txn("stream");

        // Mid-stream reset asserted between edges.
        random_txn("pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out0", bus.out0, '0);
        check("midrst_out1", bus.out1, '0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release registers the inputs present at that edge.
        drive(model(16'h1234, 16'hABCD, 16'h0F0F));
        collect("post_rst");
        for (int n = 0; n < 20; n++) random_txn("post_rst_stream");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
